// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a runtime-loaded W-bit pattern against a qualified bit stream.
// Optional saturating match counter enabled by defining SEQ_PATTERN_DETECTOR_COUNT_EN.
module seq_pattern_detector #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  pattern,
  input  logic          overlap,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          out_mealy,
  output logic          out_moore,
  output logic [CW-1:0] match_cnt
);

  localparam int FW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2,
    HIT   = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    pat_q;
  logic            ovl_q;
  logic [W-2:0]    hist;
  logic [FW-1:0]   fill;
  logic [W-1:0]    window;
  logic            match;

  assign window = {hist, in_bit};

  // HIT only carries a full history when overlapping; otherwise it was cleared on entry.
  assign match = ((state == ARMED) || ((state == HIT) && ovl_q)) &&
                 in_valid && !load && (window == pat_q);

  assign out_mealy = match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      out_moore <= 1'b0;
    end else if (load) begin
      state     <= FILL;
      pat_q     <= pattern;
      ovl_q     <= overlap;
      hist      <= '0;
      fill      <= '0;
      out_moore <= 1'b0;
    end else begin
      out_moore <= 1'b0;
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        FILL: begin
          if (in_valid) begin
            hist <= window[W-2:0];
            fill <= fill + FW'(1);
            if (fill == FW'(W - 2)) state <= ARMED;
          end
        end
        ARMED, HIT: begin
          if ((state == HIT) && !ovl_q) begin
            // A valid bit here is the first bit of a fresh window.
            if (in_valid) begin
              hist  <= window[W-2:0];
              fill  <= FW'(1);
              state <= (W == 2) ? ARMED : FILL;
            end else begin
              fill  <= '0;
              state <= FILL;
            end
          end else if (match) begin
            state     <= HIT;
            out_moore <= 1'b1;
            if (ovl_q) begin
              hist <= window[W-2:0];
            end else begin
              hist <= '0;
              fill <= '0;
            end
          end else begin
            if (in_valid) hist <= window[W-2:0];
            state <= ARMED;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (load) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CW'(1);
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed plan plus randomized traffic
// checked against a queue-based reference model; two instances (CW=8 and CW=2) share stimulus.
module tb_seq_pattern_detector;

  localparam int W = 4;
`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] pattern;
  logic         overlap;
  logic         in_valid;
  logic         in_bit;
  logic         out_mealy_a, out_moore_a, out_mealy_b, out_moore_b;
  logic [7:0]   match_cnt_a;
  logic [1:0]   match_cnt_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state: raw bit history since load (or since last non-overlap hit).
  bit           loaded;
  logic [W-1:0] pat_m;
  bit           ovl_m;
  bit           hist_q[$];
  int           cnt_a, cnt_b;
  logic         moore_exp;
  logic [W-1:0] cur_pat;
  logic         cur_ovl;

  seq_pattern_detector #(.W(W), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .pattern(pattern), .overlap(overlap),
    .in_valid(in_valid), .in_bit(in_bit),
    .out_mealy(out_mealy_a), .out_moore(out_moore_a), .match_cnt(match_cnt_a)
  );

  seq_pattern_detector #(.W(W), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .pattern(pattern), .overlap(overlap),
    .in_valid(in_valid), .in_bit(in_bit),
    .out_mealy(out_mealy_b), .out_moore(out_moore_b), .match_cnt(match_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic modelMatch(input logic ld, input logic v, input logic b);
    logic [W-1:0] w;
    if (!loaded || ld || !v || hist_q.size() < W - 1) return 1'b0;
    for (int i = 0; i < W - 1; i++) w[W-1-i] = hist_q[hist_q.size() - (W - 1) + i];
    w[0] = b;
    return w == pat_m;
  endfunction

  function automatic void modelReset();
    loaded = 1'b0;
    pat_m = '0;
    ovl_m = 1'b0;
    hist_q.delete();
    cnt_a = 0;
    cnt_b = 0;
    moore_exp = 1'b0;
  endfunction

  function automatic void modelUpdate(input logic ld, input logic [W-1:0] pat, input logic ovl,
                                      input logic v, input logic b, input logic hit);
    moore_exp = 1'b0;
    if (ld) begin
      loaded = 1'b1;
      pat_m  = pat;
      ovl_m  = ovl;
      hist_q.delete();
      cnt_a  = 0;
      cnt_b  = 0;
    end else if (loaded && v) begin
      if (hit) begin
        moore_exp = 1'b1;
        if (cnt_a < 255) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
      if (hit && !ovl_m) begin
        hist_q.delete();
      end else begin
        hist_q.push_back(b);
        while (hist_q.size() > W - 1) void'(hist_q.pop_front());
      end
    end
  endfunction

  // One clock cycle: drive at negedge, check Mealy before the edge, registered outputs after.
  task automatic applyStimulus(input logic ld, input logic [W-1:0] pat, input logic ovl,
                               input logic v, input logic b);
    logic exp_m;
    @(negedge clk);
    load = ld; pattern = pat; overlap = ovl; in_valid = v; in_bit = b;
    #1;
    exp_m = modelMatch(ld, v, b);
    checkOutput("mealy_a", {31'd0, out_mealy_a}, {31'd0, exp_m});
    checkOutput("mealy_b", {31'd0, out_mealy_b}, {31'd0, exp_m});
    @(posedge clk);
    modelUpdate(ld, pat, ovl, v, b, exp_m);
    #1;
    checkOutput("moore_a", {31'd0, out_moore_a}, {31'd0, moore_exp});
    checkOutput("moore_b", {31'd0, out_moore_b}, {31'd0, moore_exp});
    checkOutput("cnt_a", {24'd0, match_cnt_a}, COUNT_EN ? cnt_a : 0);
    checkOutput("cnt_b", {30'd0, match_cnt_b}, COUNT_EN ? cnt_b : 0);
  endtask

  task automatic doLoad(input logic [W-1:0] pat, input logic ovl, input logic v, input logic b);
    cur_pat = pat;
    cur_ovl = ovl;
    applyStimulus(1'b1, pat, ovl, v, b);
  endtask

  task automatic sendBit(input logic v, input logic b);
    applyStimulus(1'b0, cur_pat, cur_ovl, v, b);
  endtask

  // Send n bits MSB-first, with 'gap' idle cycles after each bit.
  task automatic sendBits(input logic [15:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sendBit(1'b1, bits[n-1-i]);
      for (int g = 0; g < gap; g++) sendBit(1'b0, 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mealy"}, {30'd0, out_mealy_a, out_mealy_b}, 32'd0);
    checkOutput({tag, "_moore"}, {30'd0, out_moore_a, out_moore_b}, 32'd0);
    checkOutput({tag, "_cnt"}, {22'd0, match_cnt_a, match_cnt_b}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rpat;
    int           r;
    rst_n = 1'b0; load = 1'b0; pattern = '0; overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cur_pat = '0; cur_ovl = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Mid-stream asynchronous reset, then bits with no load must be ignored.
    $display("[TB] reset and idle behaviour");
    doLoad(4'b1011, 1'b1, 1'b0, 1'b0);
    sendBits(16'b1011011, 7, 0);
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    sendBits(16'b1011, 4, 0);
    checkAllZero("idle_ignore");

    $display("[TB] non-overlapping detection");
    doLoad(4'b1011, 1'b0, 1'b0, 1'b0);
    sendBits(16'b1011011, 7, 0);
    checkOutput("nonovl_cnt", {24'd0, match_cnt_a}, COUNT_EN ? 32'd1 : 32'd0);

    $display("[TB] overlapping detection");
    doLoad(4'b1011, 1'b1, 1'b0, 1'b0);
    sendBits(16'b1011011, 7, 0);
    checkOutput("ovl_cnt", {24'd0, match_cnt_a}, COUNT_EN ? 32'd2 : 32'd0);

    $display("[TB] overlapping all-ones pattern");
    doLoad(4'b1111, 1'b1, 1'b0, 1'b0);
    sendBits(16'b111111, 6, 0);
    checkOutput("ones_cnt", {24'd0, match_cnt_a}, COUNT_EN ? 32'd3 : 32'd0);

    $display("[TB] gaps and reload");
    doLoad(4'b1011, 1'b0, 1'b0, 1'b0);
    sendBits(16'b1011, 4, 1);
    sendBits(16'b101, 3, 0);
    doLoad(4'b0000, 1'b0, 1'b1, 1'b1);
    sendBits(16'b0000, 4, 0);
    checkOutput("reload_cnt", {24'd0, match_cnt_a}, COUNT_EN ? 32'd1 : 32'd0);

    $display("[TB] counter saturation");
    doLoad(4'b1111, 1'b1, 1'b0, 1'b0);
    sendBits(16'b11111111, 8, 0);
    checkOutput("sat_cnt_b", {30'd0, match_cnt_b}, COUNT_EN ? 32'd3 : 32'd0);
    checkOutput("sat_cnt_a", {24'd0, match_cnt_a}, COUNT_EN ? 32'd5 : 32'd0);

    $display("[TB] randomized traffic");
    for (int round = 0; round < 4; round++) begin
      rpat = W'($urandom_range(0, 15));
      doLoad(rpat, round[0], 1'b1, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          rpat = W'($urandom_range(0, 15));
          doLoad(rpat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else begin
          sendBit(r < 70, 1'($urandom_range(0, 1)));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector: the next generation of the week-6 Moore/Mealy sequence machines. Instead of a fixed hard-coded state graph, it matches a runtime-loaded W-bit pattern against a qualified serial bit stream. It provides both a combinational Mealy match and a registered Moore match, with selectable overlapping or non-overlapping detection and an optional saturating match counter. It sits between a serial source and any consumer needing a pattern-hit strobe.

## Interface
- `W`, 4: pattern length in bits, legal 2..16
- `CW`, 8: match counter width, legal 1..16
- `clk` input 1: clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `load` input 1: capture `pattern` and `overlap`, restart detection
- `pattern` input W: pattern; `pattern[W-1]` is the first bit expected
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping; sampled only on `load`
- `in_valid` input 1: `in_bit` qualifier
- `in_bit` input 1: serial data, MSB-first relative to `pattern`
- `out_mealy` output 1: combinational match on the current `in_bit`
- `out_moore` output 1: registered match, high for one cycle in state HIT
- `match_cnt` output CW: number of matches since last `load`/reset

## Operation
- Internal registers: `pat_q[W-1:0]`, `ovl_q`, history `hist[W-2:0]`, fill count (0..W-1), 2-bit state, and `match_cnt`.
- Window on a valid cycle is `{hist, in_bit}`. A match is defined as `state ∈ {ARMED, HIT_FULL}` && `in_valid` && window == `pat_q`.
- `out_mealy` = match. It is purely combinational from `in_valid` and `in_bit` in the same cycle.
- States:
  - IDLE: entered on reset. Inputs are ignored and all outputs are 0. `load` -> FILL with fill=0.
  - FILL: on `in_valid`, shift `in_bit` into `hist` and increment fill. When fill reaches W-1 -> ARMED.
  - ARMED: on `in_valid`, shift. Match -> HIT; no match -> stay ARMED.
  - HIT: `out_moore`=1. Lasts one cycle unless re-matched.
    - With `ovl_q`=1 the history is full (HIT_FULL): match -> HIT, otherwise ARMED. The shift happens either way.
    - With `ovl_q`=0, `hist` and fill were cleared on entry. A valid bit in HIT is the first bit of a new window, giving fill=1, which -> ARMED if W=2, else FILL. No valid bit -> FILL with fill=0.
- Transitions into HIT with `ovl_q`=0 clear `hist` and fill in the same edge.
- `load` (any state): `pat_q`<=`pattern`, `ovl_q`<=`overlap`, `hist`<=0, fill<=0, `match_cnt`<=0, next state FILL. `load` has priority over `in_valid`; the bit presented in the same cycle is discarded and `out_mealy` is forced to 0 that cycle.
- `in_valid`=0: state, history and fill hold. The exception is HIT, which always leaves after one cycle.
- Illegal state encoding -> IDLE.

## Timing
- Reset (async assert, sync-safe release): state=IDLE; `out_mealy`=0, `out_moore`=0, `match_cnt`=0, `pat_q`=0, `ovl_q`=0, `hist`=0.
- `out_mealy`: 0-cycle latency from the final pattern bit.
- `out_moore`: high in the cycle after the edge that sampled the final pattern bit (1-cycle latency). Consecutive overlapped matches hold it high continuously.
- `match_cnt`: updates at the edge that samples a match, so it is visible the same cycle `out_moore` rises.
- First possible match: the W-th valid bit after `load`.

## Configuration
- `SEQ_PATTERN_DETECTOR_COUNT_EN` defined:
  - `match_cnt` increments by 1 on every match.
  - It saturates at 2^CW-1 and does not wrap.
  - It is cleared by reset or `load`.
- `SEQ_PATTERN_DETECTOR_COUNT_EN` undefined: the counter logic is omitted and `match_cnt` is tied to 0. All other behaviour is identical.

## Test plan
Defaults are W=4, CW=8 unless stated.

1. **Reset/IDLE:** assert `rst_n`=0 mid-stream -> all outputs 0 immediately. Drive valid bits 1,0,1,1 with no `load` -> no `out_mealy`/`out_moore`, `match_cnt`=0.
2. **Non-overlap:** `load` `pattern`=4'b1011, `overlap`=0, then valid stream 1,0,1,1,0,1,1 ->
   - `out_mealy` high on bit 4 only;
   - `out_moore` high one cycle after bit 4;
   - `match_cnt`=1 at end.
3. **Overlap:** same pattern with `overlap`=1 and the same stream -> `out_mealy` on bits 4 and 7, `match_cnt`=2.
4. **Overlap on pattern 4'b1111:** stream six 1s -> matches on bits 4, 5, 6, and `out_moore` high for 3 consecutive cycles.
5. **Gaps and reload:**
   - With pattern 1011, insert `in_valid`=0 gaps between every bit -> the match is still detected and `out_moore` is exactly one cycle.
   - After 1,0,1, pulse `load` with `pattern`=4'b0000 together with `in_bit`=1 valid -> no match, and the bit is discarded. Four 0s then produce a match on the 4th.
6. **Counter:** CW=2, overlap, pattern 4'b1111, stream eight 1s ->
   - with the macro defined, `match_cnt` saturates at 3;
   - with the macro undefined, `match_cnt` stays 0 throughout.
